// File: rtl/intersection_ctrl.sv
// Two-approach traffic light controller with pedestrian phase.
// Green rests on demand absence; walk is inserted after all-red.
module intersection_ctrl #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW    = 2,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned WALK      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5,
    PED   = 3'd6
  } state_t;

  localparam logic [4:0] MIN_E = 5'(MIN_GREEN);
  localparam logic [4:0] MAX_E = 5'(MAX_GREEN);
  localparam logic [4:0] YEL_E = 5'(YELLOW);
  localparam logic [4:0] AR_E  = 5'(ALL_RED);
  localparam logic [4:0] WLK_E = 5'(WALK);
  localparam logic [3:0] T_MAX = 4'(MAX_GREEN);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       ped_q, ped_d;
  logic       dir_q, dir_d;
  logic [4:0] elapsed;
  logic       ns_dem, ew_dem;
  logic       green, enter_ped;

  assign elapsed   = {1'b0, timer_q} + 5'd1;
  assign ns_dem    = ew_car | ped_q;
  assign ew_dem    = ns_car | ped_q;
  assign green     = (state_q == NS_G) || (state_q == EW_G);
  assign enter_ped = (state_d == PED) && (state_q != PED);

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        NS_G: begin
          if (ns_dem && ((elapsed >= MIN_E && !ns_car) ||
                         elapsed >= MAX_E))
            state_d = NS_Y;
        end
        NS_Y:  if (elapsed == YEL_E) state_d = AR_NS;
        AR_NS: begin
          if (elapsed == AR_E)
            state_d = ped_q ? PED : EW_G;
        end
        EW_G: begin
          if (ew_dem && ((elapsed >= MIN_E && !ew_car) ||
                         elapsed >= MAX_E))
            state_d = EW_Y;
        end
        EW_Y:  if (elapsed == YEL_E) state_d = AR_EW;
        AR_EW: begin
          if (elapsed == AR_E)
            state_d = ped_q ? PED : NS_G;
        end
        PED: begin
          // dir_q=0: north-south preceded the walk, so east-west is next
          if (elapsed == WLK_E)
            state_d = dir_q ? NS_G : EW_G;
        end
        default: state_d = NS_G;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = 4'd0;
    else if (tick && !(green && timer_q == T_MAX))
      timer_d = timer_q + 4'd1;
  end

  always_comb begin
    dir_d = dir_q;
    if (enter_ped)
      dir_d = (state_q == AR_EW);
    ped_d = ped_q | (ped_req && state_q != PED);
    if (enter_ped)
      ped_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NS_G;
      timer_q <= 4'd0;
      ped_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b0;
    walk = 1'b0;
    unique case (1'b1)
      state_q == NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      state_q == NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      state_q == EW_G: begin ns_r = 1'b1; ew_g = 1'b1; end
      state_q == EW_Y: begin ns_r = 1'b1; ew_y = 1'b1; end
      state_q == PED: begin
        ns_r = 1'b1;
        ew_r = 1'b1;
        walk = 1'b1;
      end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: directed scenarios
// followed by random traffic, checked against a cycle model.
module tb_intersection_ctrl;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 2;
  localparam int ARED  = 1;
  localparam int WLK   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic ns_car = 1'b0;
  logic ew_car = 1'b0;
  logic ped_req = 1'b0;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending;
  logic [2:0] phase;

  intersection_ctrl #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL),
    .ALL_RED(ARED), .WALK(WLK)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int pend;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // model state: phase number, ticks spent in it, pending flag,
  // and the green to resume after the walk
  int m_phase = 0;
  int m_cnt = 0;
  int m_pend = 0;
  int m_after = 3;

  function automatic logic [6:0] lamps(input int p);
    case (p)
      0: return 7'b100_001_0;
      1: return 7'b010_001_0;
      3: return 7'b001_100_0;
      4: return 7'b001_010_0;
      6: return 7'b001_001_1;
      default: return 7'b001_001_0;
    endcase
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit t, input bit ns,
                                     input bit ew, input bit pr,
                                     input bit r);
    int np;
    int e;
    int npend;
    if (r) begin
      m_phase = 0;
      m_cnt = 0;
      m_pend = 0;
      m_after = 3;
      return;
    end
    np = m_phase;
    e = m_cnt + 1;
    if (t) begin
      case (m_phase)
        0: if ((ew || m_pend != 0) &&
               ((e >= MIN_G && !ns) || e >= MAX_G)) np = 1;
        1: if (e == YEL) np = 2;
        2: if (e == ARED) np = (m_pend != 0) ? 6 : 3;
        3: if ((ns || m_pend != 0) &&
               ((e >= MIN_G && !ew) || e >= MAX_G)) np = 4;
        4: if (e == YEL) np = 5;
        5: if (e == ARED) np = (m_pend != 0) ? 6 : 0;
        6: if (e == WLK) np = m_after;
        default: np = 0;
      endcase
    end
    npend = (m_pend != 0 || (pr && m_phase != 6)) ? 1 : 0;
    if (np == 6 && m_phase != 6) begin
      npend = 0;
      m_after = (m_phase == 2) ? 3 : 0;
    end
    if (np != m_phase) m_cnt = 0;
    else if (t) m_cnt++;
    m_phase = np;
    m_pend = npend;
  endfunction

  task automatic cyc(input bit t, input bit ns, input bit ew,
                     input bit pr, input bit r);
    exp_t e;
    @(negedge clk);
    tick = t;
    ns_car = ns;
    ew_car = ew;
    ped_req = pr;
    rst = r;
    model_step(t, ns, ew, pr, r);
    e.phase = m_phase;
    e.pend = m_pend;
    q.push_back(e);
  endtask

  task automatic ticks(input int n, input bit ns, input bit ew);
    for (int i = 0; i < n; i++) cyc(1'b1, ns, ew, 1'b0, 1'b0);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("phase", int'(phase), e.phase);
        check("ped_pending", int'(ped_pending), e.pend);
        check("lamps",
              int'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}),
              int'(lamps(e.phase)));
        check("ns_onehot", int'($countones({ns_g, ns_y, ns_r})), 1);
        check("ew_onehot", int'($countones({ew_g, ew_y, ew_r})), 1);
        check("no_dual_green", int'(ns_g & ew_g), 0);
      end
    end
  end

  initial begin : driver
    bit cn, ce;
    int w;
    // reset, then idle rest in NS green
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    after_edge();
    check("reset_phase", int'(phase), 0);
    check("reset_walk", int'(walk), 0);
    ticks(20, 1'b0, 1'b0);
    after_edge();
    check("idle_phase", int'(phase), 0);
    check("idle_ns_g", int'(ns_g & ew_r), 1);

    // east-west demand only: min green then clearance
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3, 1'b0, 1'b1);
    after_edge();
    check("ew_ng_hold", int'(phase), 0);
    ticks(1, 1'b0, 1'b1);
    after_edge();
    check("ew_ng_exit", int'(phase), 1);
    ticks(2, 1'b0, 1'b1);
    after_edge();
    check("ew_ar", int'(phase), 2);
    ticks(1, 1'b0, 1'b1);
    after_edge();
    check("ew_green", int'(phase), 3);

    // both approaches busy: max green each way
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    ticks(9, 1'b1, 1'b1);
    after_edge();
    check("max_ns_hold", int'(phase), 0);
    ticks(1, 1'b1, 1'b1);
    after_edge();
    check("max_ns_exit", int'(phase), 1);
    ticks(3, 1'b1, 1'b1);
    ticks(9, 1'b1, 1'b1);
    after_edge();
    check("max_ew_hold", int'(phase), 3);
    ticks(1, 1'b1, 1'b1);
    after_edge();
    check("max_ew_exit", int'(phase), 4);

    // pedestrian pulse during idle NS green
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(5, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    check("ped_latched", int'(ped_pending), 1);
    ticks(1, 1'b0, 1'b0);
    after_edge();
    check("ped_ns_y", int'(phase), 1);
    ticks(3, 1'b0, 1'b0);
    after_edge();
    check("ped_phase", int'(phase), 6);
    check("ped_walk", int'(walk), 1);
    check("ped_cleared", int'(ped_pending), 0);
    ticks(2, 1'b0, 1'b0);
    after_edge();
    check("ped_still", int'(phase), 6);
    ticks(1, 1'b0, 1'b0);
    after_edge();
    check("ped_to_ew", int'(phase), 3);

    // request coincides with entry into walk; request during walk
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    check("coin_phase", int'(phase), 6);
    check("coin_pend", int'(ped_pending), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3, 1'b0, 1'b0);
    ticks(10, 1'b0, 1'b0);
    after_edge();
    check("coin_rest", int'(phase), 3);
    check("coin_nowalk", int'(walk), 0);
    check("coin_pend_end", int'(ped_pending), 0);

    // reset in the middle of a walk
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(4, 1'b0, 1'b0);
    ticks(1, 1'b0, 1'b0);
    after_edge();
    check("midped_in", int'(phase), 6);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    after_edge();
    check("midped_phase", int'(phase), 0);
    check("midped_walk", int'(walk), 0);
    check("midped_pend", int'(ped_pending), 0);

    // random traffic
    cn = 1'b0;
    ce = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) cn = ~cn;
      if ($urandom_range(0, 15) == 0) ce = ~ce;
      cyc(1'($urandom_range(0, 1)), cn, ce,
          1'($urandom_range(0, 40) == 0),
          1'($urandom_range(0, 600) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter MIN_GREEN, 4: minimum green duration, in ticks.
REQ-002 Parameter MAX_GREEN, 10: maximum green duration when the other approach has demand, in ticks.
REQ-003 Parameter YELLOW, 2: yellow duration, in ticks.
REQ-004 Parameter ALL_RED, 1: all-red clearance duration, in ticks.
REQ-005 Parameter WALK, 3: pedestrian walk duration, in ticks. All parameters SHALL be in the range 1..15, with MIN_GREEN <= MAX_GREEN.
REQ-006 clk  in  1  single clock; all state changes occur on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  timebase enable, one pulse per time unit; every cycle with tick=1 counts as one tick.
REQ-009 ns_car  in  1  north-south vehicle sensor, level-sensitive.
REQ-010 ew_car  in  1  east-west vehicle sensor, level-sensitive.
REQ-011 ped_req  in  1  pedestrian button, a pulse of any width.
REQ-012 ns_g, ns_y, ns_r  out  1 each  north-south lamps, one-hot.
REQ-013 ew_g, ew_y, ew_r  out  1 each  east-west lamps, one-hot.
REQ-014 walk  out  1  pedestrian walk lamp.
REQ-015 ped_pending  out  1  latched, not-yet-served pedestrian request.
REQ-016 phase  out  3  current state encoding: NS_G=0, NS_Y=1, AR_NS=2, EW_G=3, EW_Y=4, AR_EW=5, PED=6.

Function
REQ-017 Lamp and walk outputs SHALL be Moore-decoded from phase:
- NS_G: ns_g, ew_r.
- NS_Y: ns_y, ew_r.
- EW_G: ns_r, ew_g.
- EW_Y: ns_r, ew_y.
- AR_NS, AR_EW, PED: ns_r and ew_r.
- walk=1 only in PED.
REQ-018 A 4-bit timer SHALL hold the number of ticks elapsed in the current state, clear to 0 on every state change, and saturate at MAX_GREEN while in a green state.
REQ-019 State changes SHALL occur only on cycles with tick=1; "elapsed" denotes timer+1 on that cycle.
REQ-020 In NS_G, other_dem = ew_car | ped_pending. Exit to NS_Y SHALL occur when other_dem && ((elapsed >= MIN_GREEN && !ns_car) || elapsed >= MAX_GREEN).
REQ-021 EW_G SHALL follow the rule of REQ-020 symmetrically, with other_dem = ns_car | ped_pending and own sensor ew_car, exiting to EW_Y.
REQ-022 With other_dem=0, the green state SHALL persist indefinitely (rest in green).
REQ-023 NS_Y SHALL go to AR_NS, and EW_Y to AR_EW, when elapsed == YELLOW.
REQ-024 AR_NS SHALL exit when elapsed == ALL_RED: to PED if ped_pending, else to EW_G. AR_EW SHALL exit likewise: to PED, else to NS_G.
REQ-025 PED SHALL exit when elapsed == WALK, to the green opposite the approach that preceded it; a 1-bit next_dir register SHALL record that approach on entry to PED.
REQ-026 ped_pending SHALL be set in the cycle after any cycle with ped_req=1, and cleared on the edge that enters PED; if set and clear coincide, clear wins.
REQ-027 ped_req asserted while in PED SHALL be ignored.
REQ-028 Sensors SHALL be sampled only on tick cycles; sensor changes between ticks have no effect.
REQ-029 Exactly one of the g/y/r lamps per approach SHALL be asserted in every cycle, and ns_g & ew_g SHALL never both be 1.

Reset
REQ-030 When rst=1 at a clock edge, the next state SHALL be:
- phase=NS_G, timer=0, ped_pending=0, next_dir=NS.
- Outputs: ns_g=1, ew_r=1, all other lamps 0, walk=0.
REQ-031 rst SHALL take priority over tick, ped_req and any pending transition, including when asserted mid-yellow or mid-walk.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset, no demand, 20 ticks: phase stays 0, ns_g=1, ew_r=1 throughout.
- ew_car=1 and ns_car=0 from reset: NS_G exits on tick 4; then NS_Y for 2 ticks, AR_NS for 1, EW_G.
- ns_car=1 and ew_car=1 held: NS_G held to MAX_GREEN, exits on tick 10; EW_G then also lasts 10 ticks.
- ped_req pulse during NS_G with no cars: ped_pending=1 next cycle; sequence NS_Y → AR_NS → PED (walk=1, 3 ticks, ped_pending=0) → EW_G.
- ped_req coinciding with the tick that enters PED: ped_pending ends 0 and no second walk phase occurs.
- rst asserted mid-PED: next cycle phase=0, walk=0, ped_pending=0; tick high in the same cycle is ignored.
